// File: rtl/mem_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_e;

   localparam int LD_LB  = 0;
   localparam int LD_LH  = 1;
   localparam int LD_LW  = 2;
   localparam int LD_LBU = 3;
   localparam int LD_LHU = 4;

   localparam int ST_SB = 0;
   localparam int ST_SH = 1;
   localparam int ST_SW = 2;

   localparam logic [3:0] BE_ALL = 4'b1111;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_B0  = 4'b0001;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, load extraction/extension and misalign detect.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic        memwrite,
   input  logic [4:0]  loadcntrl,
   input  logic [2:0]  storecntrl,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        mis
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        half_acc;
   logic        word_acc;

   always_comb begin
      be    = BE_ALL;
      wdata = rs2;
      if (memwrite) begin
         if (storecntrl[ST_SB]) begin
            be    = BE_B0 << addr_lo;
            wdata = {4{rs2[7:0]}};
         end else if (storecntrl[ST_SH]) begin
            be    = addr_lo[1] ? BE_HI : BE_LO;
            wdata = {2{rs2[15:0]}};
         end
      end
   end

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      ld_data  = rdata;
      if (loadcntrl[LD_LB])
         ld_data = {{24{byte_sel[7]}}, byte_sel};
      else if (loadcntrl[LD_LBU])
         ld_data = {24'b0, byte_sel};
      else if (loadcntrl[LD_LH])
         ld_data = {{16{half_sel[15]}}, half_sel};
      else if (loadcntrl[LD_LHU])
         ld_data = {16'b0, half_sel};
   end

   // Byte accesses can never be misaligned, so they do not appear here.
   assign half_acc = loadcntrl[LD_LH] | loadcntrl[LD_LHU] | storecntrl[ST_SH];
   assign word_acc = loadcntrl[LD_LW] | storecntrl[ST_SW];
   assign mis      = (half_acc & addr_lo[0]) | (word_acc & (|addr_lo));

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: dmem req/ack handshake with wait states, timeout,
// debug freeze and the MEM/WB pipeline register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        dbg,
   input  logic [31:0] EX_MEM_alures,
   input  logic [31:0] EX_MEM_mulres,
   input  logic [31:0] EX_MEM_divres,
   input  logic        EX_MEM_mul_ready,
   input  logic        EX_MEM_div_ready,
   input  logic [31:0] EX_MEM_dout_rs2,
   input  logic [4:0]  EX_MEM_rd,
   input  logic        EX_MEM_memread,
   input  logic        EX_MEM_memwrite,
   input  logic        EX_MEM_regwrite,
   input  logic [4:0]  EX_MEM_loadcntrl,
   input  logic [2:0]  EX_MEM_storecntrl,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_hold,
   output logic [4:0]  MEM_WB_rd,
   output logic        MEM_WB_regwrite,
   output logic [31:0] WB_res,
   output logic        mem_fault,
   output logic [31:0] mem_fault_addr
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [4:0]         rd_q, rd_d;
   logic               rw_q, rw_d;
   logic [31:0]        wb_q, wb_d;
   logic               fault_q, fault_d;
   logic [31:0]        faddr_q, faddr_d;

   logic               acc;
   logic               mis;
   logic [31:0]        ld_src;
   logic [31:0]        ld_data;
   logic [31:0]        nonmem_res;
   logic               ret_rw;
   logic [31:0]        ret_res;

   assign acc    = EX_MEM_memread | EX_MEM_memwrite;
   // Once HOLD is entered the bus word is gone, so use the captured copy.
   assign ld_src = (state_q == HOLD) ? rdata_q : dmem_rdata;

   mem_align u_align (
      .addr_lo    (EX_MEM_alures[1:0]),
      .memwrite   (EX_MEM_memwrite),
      .loadcntrl  (EX_MEM_loadcntrl),
      .storecntrl (EX_MEM_storecntrl),
      .rs2        (EX_MEM_dout_rs2),
      .rdata      (ld_src),
      .be         (dmem_be),
      .wdata      (dmem_wdata),
      .ld_data    (ld_data),
      .mis        (mis)
   );

   assign nonmem_res = EX_MEM_mul_ready ? EX_MEM_mulres :
                       EX_MEM_div_ready ? EX_MEM_divres : EX_MEM_alures;
   assign ret_rw     = EX_MEM_regwrite & ~EX_MEM_memwrite;
   assign ret_res    = EX_MEM_memread  ? ld_data :
                       EX_MEM_memwrite ? 32'h0   : nonmem_res;

   assign dmem_req  = ((state_q == IDLE) & acc & ~mis & ~dbg) | (state_q == WAIT);
   assign dmem_we   = EX_MEM_memwrite;
   assign dmem_addr = {EX_MEM_alures[31:2], 2'b00};
   assign mem_hold  = (dmem_req & ~dmem_ack) | ((state_q == HOLD) & dbg) |
                      ((state_q == IDLE) & acc & dbg);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      wb_d    = wb_q;
      fault_d = 1'b0;
      faddr_d = faddr_q;
      case (state_q)
         IDLE: begin
            if (!dbg) begin
               if (acc && mis) begin
                  fault_d = 1'b1;
                  faddr_d = EX_MEM_alures;
                  rd_d    = EX_MEM_rd;
                  rw_d    = 1'b0;
                  wb_d    = 32'h0;
               end else if (!acc || dmem_ack) begin
                  rd_d = EX_MEM_rd;
                  rw_d = ret_rw;
                  wb_d = ret_res;
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end
            end
         end
         WAIT: begin
            if (dmem_ack) begin
               if (!dbg) begin
                  rd_d    = EX_MEM_rd;
                  rw_d    = ret_rw;
                  wb_d    = ret_res;
                  state_d = IDLE;
               end else begin
                  rdata_d = dmem_rdata;
                  state_d = HOLD;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               fault_d = 1'b1;
               faddr_d = EX_MEM_alures;
               rd_d    = EX_MEM_rd;
               rw_d    = 1'b0;
               wb_d    = 32'h0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!dbg) begin
               rd_d    = EX_MEM_rd;
               rw_d    = ret_rw;
               wb_d    = ret_res;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 5'd0;
         rw_q    <= 1'b0;
         wb_q    <= 32'h0;
         fault_q <= 1'b0;
         faddr_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         wb_q    <= wb_d;
         fault_q <= fault_d;
         faddr_q <= faddr_d;
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign MEM_WB_rd       = rd_q;
   assign MEM_WB_regwrite = rw_q;
   assign WB_res          = wb_q;
   assign mem_fault       = fault_q;
   assign mem_fault_addr  = faddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus wait-state,
// timeout, reset and debug-freeze sequences.
module tb_mem_stage;

   localparam int TO = 8;

   logic        clk;
   logic        Rst;
   logic        dbg;
   logic [31:0] alures, mulres, divres, rs2, rdata;
   logic        mul_rdy, div_rdy, memread, memwrite, regwrite, ack;
   logic [4:0]  rd, loadcntrl;
   logic [2:0]  storecntrl;
   logic        dmem_req, dmem_we, mem_hold, MEM_WB_regwrite, mem_fault;
   logic [31:0] dmem_addr, dmem_wdata, WB_res, mem_fault_addr;
   logic [3:0]  dmem_be;
   logic [4:0]  MEM_WB_rd;

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage #(.TIMEOUT(TO), .CNT_W(4)) dut (
      .clk               (clk),
      .Rst               (Rst),
      .dbg               (dbg),
      .EX_MEM_alures     (alures),
      .EX_MEM_mulres     (mulres),
      .EX_MEM_divres     (divres),
      .EX_MEM_mul_ready  (mul_rdy),
      .EX_MEM_div_ready  (div_rdy),
      .EX_MEM_dout_rs2   (rs2),
      .EX_MEM_rd         (rd),
      .EX_MEM_memread    (memread),
      .EX_MEM_memwrite   (memwrite),
      .EX_MEM_regwrite   (regwrite),
      .EX_MEM_loadcntrl  (loadcntrl),
      .EX_MEM_storecntrl (storecntrl),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_be           (dmem_be),
      .dmem_wdata        (dmem_wdata),
      .dmem_ack          (ack),
      .dmem_rdata        (rdata),
      .mem_hold          (mem_hold),
      .MEM_WB_rd         (MEM_WB_rd),
      .MEM_WB_regwrite   (MEM_WB_regwrite),
      .WB_res            (WB_res),
      .mem_fault         (mem_fault),
      .mem_fault_addr    (mem_fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] alu; logic [31:0] mul; logic [31:0] dv;
      logic mrdy; logic drdy; logic [31:0] rs2; logic [4:0] rd;
      logic mr; logic mw; logic rw; logic [4:0] lc; logic [2:0] sc;
      logic ack; logic [31:0] rdata;
      logic e_req; logic [3:0] e_be; logic [31:0] e_wd; logic chk_wd;
      logic e_hold; logic e_rw; logic [31:0] e_res; logic e_fault;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      alures = 32'h0; mulres = 32'h0; divres = 32'h0; rs2 = 32'h0; rdata = 32'h0;
      mul_rdy = 1'b0; div_rdy = 1'b0; memread = 1'b0; memwrite = 1'b0;
      regwrite = 1'b0; ack = 1'b0; rd = 5'd0; loadcntrl = 5'd0; storecntrl = 3'd0;
   endtask

   task automatic load_wait(input string nm, input logic [31:0] a, input logic [4:0] lc,
                            input logic [31:0] word, input int nw, input logic [31:0] exp);
      int holds;
      holds = 0;
      nop();
      alures = a; memread = 1'b1; regwrite = 1'b1; loadcntrl = lc; rd = 5'd11;
      for (int k = 0; k < nw; k++) begin
         #2;
         if (mem_hold) holds++;
         tick();
      end
      chk({nm, "_hold_cycles"}, 32'(holds), 32'(nw));
      ack = 1'b1; rdata = word;
      #2;
      chk({nm, "_hold_on_ack"}, 32'(mem_hold), 32'h0);
      tick();
      ack = 1'b0;
      chk({nm, "_res"}, WB_res, exp);
      chk({nm, "_rw"}, 32'(MEM_WB_regwrite), 32'h1);
      nop();
   endtask

   initial begin
      int cyc;
      bit seen;

      //      alu          mul          div          mrdy  drdy  rs2           rd     mr    mw    rw    lc        sc      ack   rdata         req   be     wd            chkwd hold  rw    res           fault
      vt[0]  = '{32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd5,  1'b1, 1'b0, 1'b1, 5'b00100, 3'b000, 1'b1, 32'hDEADBEEF, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
      vt[1]  = '{32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234ABCD, 5'd6,  1'b0, 1'b1, 1'b1, 5'b00000, 3'b010, 1'b1, 32'h0,        1'b1, 4'hC, 32'hABCDABCD, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
      vt[2]  = '{32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 32'h000000CD, 5'd7,  1'b0, 1'b1, 1'b0, 5'b00000, 3'b001, 1'b1, 32'h0,        1'b1, 4'h2, 32'hCDCDCDCD, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
      vt[3]  = '{32'h104, 32'h0, 32'h0, 1'b0, 1'b0, 32'h11223344, 5'd7,  1'b0, 1'b1, 1'b0, 5'b00000, 3'b100, 1'b1, 32'h0,        1'b1, 4'hF, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0};
      vt[4]  = '{32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 5'b00010, 3'b000, 1'b1, 32'h80017FFF, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'hFFFF8001, 1'b0};
      vt[5]  = '{32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd8,  1'b1, 1'b0, 1'b1, 5'b10000, 3'b000, 1'b1, 32'h80017FFF, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00008001, 1'b0};
      vt[6]  = '{32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd9,  1'b1, 1'b0, 1'b1, 5'b00001, 3'b000, 1'b1, 32'h00008000, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0};
      vt[7]  = '{32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd9,  1'b1, 1'b0, 1'b1, 5'b01000, 3'b000, 1'b1, 32'h000000F0, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h000000F0, 1'b0};
      vt[8]  = '{32'h11,  32'h22,32'h33,1'b1, 1'b1, 32'h0,        5'd12, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b1, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h22,       1'b0};
      vt[9]  = '{32'h11,  32'h22,32'h33,1'b0, 1'b1, 32'h0,        5'd13, 1'b0, 1'b0, 1'b1, 5'b00000, 3'b000, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h33,       1'b0};
      vt[10] = '{32'h11,  32'h22,32'h33,1'b0, 1'b0, 32'h0,        5'd14, 1'b0, 1'b0, 1'b0, 5'b00000, 3'b000, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h11,       1'b0};
      vt[11] = '{32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd15, 1'b1, 1'b0, 1'b1, 5'b00100, 3'b000, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      vt[12] = '{32'h103, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd16, 1'b0, 1'b1, 1'b0, 5'b00000, 3'b010, 1'b0, 32'h0,        1'b0, 4'hC, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      vt[13] = '{32'h201, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd17, 1'b1, 1'b0, 1'b1, 5'b00010, 3'b000, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b1};
      vt[14] = '{32'h103, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,        5'd18, 1'b1, 1'b0, 1'b1, 5'b00001, 3'b000, 1'b1, 32'h7F000000, 1'b1, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000007F, 1'b0};

      nop();
      dbg = 1'b0;
      Rst = 1'b1;
      tick();
      tick();
      chk("rst_req", 32'(dmem_req), 32'h0);
      chk("rst_rw", 32'(MEM_WB_regwrite), 32'h0);
      chk("rst_res", WB_res, 32'h0);
      chk("rst_rd", 32'(MEM_WB_rd), 32'h0);
      chk("rst_fault", 32'(mem_fault), 32'h0);
      chk("rst_faddr", mem_fault_addr, 32'h0);
      Rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         alures = vt[i].alu; mulres = vt[i].mul; divres = vt[i].dv;
         mul_rdy = vt[i].mrdy; div_rdy = vt[i].drdy; rs2 = vt[i].rs2; rd = vt[i].rd;
         memread = vt[i].mr; memwrite = vt[i].mw; regwrite = vt[i].rw;
         loadcntrl = vt[i].lc; storecntrl = vt[i].sc; ack = vt[i].ack; rdata = vt[i].rdata;
         #2;
         chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vt[i].e_req));
         chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vt[i].mw));
         chk($sformatf("v%0d_addr", i), dmem_addr, {vt[i].alu[31:2], 2'b00});
         chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vt[i].e_be));
         chk($sformatf("v%0d_hold", i), 32'(mem_hold), 32'(vt[i].e_hold));
         if (vt[i].chk_wd) chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wd);
         tick();
         chk($sformatf("v%0d_rw", i), 32'(MEM_WB_regwrite), 32'(vt[i].e_rw));
         chk($sformatf("v%0d_rd", i), 32'(MEM_WB_rd), 32'(vt[i].rd));
         chk($sformatf("v%0d_fault", i), 32'(mem_fault), 32'(vt[i].e_fault));
         if (vt[i].e_fault) chk($sformatf("v%0d_faddr", i), mem_fault_addr, vt[i].alu);
         else chk($sformatf("v%0d_res", i), WB_res, vt[i].e_res);
      end
      nop();
      tick();
      chk("fault_addr_held", mem_fault_addr, 32'h201);

      load_wait("lb_wait", 32'h103, 5'b00001, 32'h80FFFF7F, 3, 32'hFFFFFF80);
      load_wait("lbu_wait", 32'h103, 5'b01000, 32'h80FFFF7F, 3, 32'h00000080);

      // Timeout: no ack ever arrives.
      nop();
      alures = 32'h200; memread = 1'b1; regwrite = 1'b1; loadcntrl = 5'b00100; rd = 5'd19;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 50) begin
         tick();
         cyc++;
         if (mem_fault) seen = 1'b1;
      end
      chk("to_cycles", 32'(cyc), 32'(TO + 1));
      chk("to_faddr", mem_fault_addr, 32'h200);
      chk("to_rw", 32'(MEM_WB_regwrite), 32'h0);
      nop();
      alures = 32'h55; regwrite = 1'b1; rd = 5'd20;
      #2;
      chk("to_req_drop", 32'(dmem_req), 32'h0);
      tick();
      chk("to_fault_pulse", 32'(mem_fault), 32'h0);
      chk("to_idle_retire", WB_res, 32'h55);

      // Reset in the middle of a wait-state access.
      nop();
      alures = 32'h300; memread = 1'b1; regwrite = 1'b1; loadcntrl = 5'b00100; rd = 5'd21;
      tick();
      tick();
      tick();
      Rst = 1'b1;
      nop();
      tick();
      Rst = 1'b0;
      chk("rstw_req", 32'(dmem_req), 32'h0);
      chk("rstw_rw", 32'(MEM_WB_regwrite), 32'h0);
      chk("rstw_res", WB_res, 32'h0);
      ack = 1'b1;
      #2;
      chk("rstw_stray_ack_hold", 32'(mem_hold), 32'h0);
      ack = 1'b0;

      // Debug freeze during a wait-state access.
      nop();
      alures = 32'hAA; regwrite = 1'b1; rd = 5'd3;
      tick();
      chk("dbg_pre_res", WB_res, 32'hAA);
      nop();
      alures = 32'h300; memread = 1'b1; regwrite = 1'b1; loadcntrl = 5'b00100; rd = 5'd10;
      #2;
      chk("dbg_req", 32'(dmem_req), 32'h1);
      tick();
      dbg = 1'b1;
      #2;
      chk("dbg_wait_hold", 32'(mem_hold), 32'h1);
      tick();
      ack = 1'b1; rdata = 32'h5;
      tick();
      ack = 1'b0; rdata = 32'hFFFF;
      chk("dbg_hold_state", 32'(mem_hold), 32'h1);
      chk("dbg_hold_noreq", 32'(dmem_req), 32'h0);
      chk("dbg_hold_res", WB_res, 32'hAA);
      tick();
      chk("dbg_hold2", 32'(mem_hold), 32'h1);
      chk("dbg_hold2_res", WB_res, 32'hAA);
      dbg = 1'b0;
      #2;
      chk("dbg_release_hold", 32'(mem_hold), 32'h0);
      tick();
      chk("dbg_release_res", WB_res, 32'h5);
      chk("dbg_release_rw", 32'(MEM_WB_regwrite), 32'h1);
      chk("dbg_release_rd", 32'(MEM_WB_rd), 32'd10);

      // dbg with no access outstanding freezes MEM/WB; dbg with a pending access holds.
      nop();
      dbg = 1'b1;
      alures = 32'h77; regwrite = 1'b1; rd = 5'd4;
      tick();
      chk("dbg_nonmem_frozen", WB_res, 32'h5);
      memread = 1'b1; loadcntrl = 5'b00100; alures = 32'h400;
      #2;
      chk("dbg_idle_acc_req", 32'(dmem_req), 32'h0);
      chk("dbg_idle_acc_hold", 32'(mem_hold), 32'h1);
      memread = 1'b0; loadcntrl = 5'b00000; alures = 32'h77;
      dbg = 1'b0;
      tick();
      chk("dbg_off_res", WB_res, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
